// File: rtl/mux_sel_buffered.sv
// mux_sel_buffered
//   Parametrised N-input word selector feeding a 2-entry output buffer with a
//   valid/ready handshake on both sides. An accepted request with an
//   out-of-range selector stores a zero word and raises a sticky error flag.
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        synchronous active-low reset
//   in_valid     request (selector + data_in) valid
//   in_ready     buffer has room; decoded from the registered fill level only
//   selector     index of the word to pass
//   data_in      packed input words, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid    data_output holds a buffered result
//   out_ready    consumer takes data_output this cycle
//   data_output  head-of-buffer word
//   sel_error    sticky out-of-range flag
//   clear_err    synchronous clear of sel_error (a same-cycle set wins)
//   err_count    (only with MUX_ERR_COUNT_EN) saturating count of
//                out-of-range pushes, cleared by clear_err
//
// Build option: define MUX_ERR_COUNT_EN to add the err_count port and counter.

module mux_sel_buffered #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 8,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SEL_WIDTH-1:0]             selector,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            data_output,
  output logic                             sel_error,
  input  logic                             clear_err
`ifdef MUX_ERR_COUNT_EN
  ,
  output logic [7:0]                       err_count
`endif
);

  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [DATA_WIDTH-1:0] sel_word;
  logic                  in_range;
  logic                  push;
  logic                  pop;
  logic                  bad_push;

  // Scan the inputs rather than part-selecting with the selector, so an
  // out-of-range index never reaches past the packed bus.
  always_comb begin
    sel_word = '0;
    in_range = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (selector == SEL_WIDTH'(i)) begin
        sel_word = data_in[i*DATA_WIDTH +: DATA_WIDTH];
        in_range = 1'b1;
      end
    end
  end

  assign in_ready    = (count != 2'd2);
  assign out_valid   = (count != 2'd0);
  assign data_output = head;
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign bad_push    = push & ~in_range;

  // head is left untouched when the buffer drains, so data_output stays
  // stable at the last delivered word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head  <= sel_word;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= sel_word;
          end else if (push) begin
            tail  <= sel_word;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head  <= tail;
            count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_error <= 1'b0;
    end else if (bad_push) begin
      sel_error <= 1'b1;
    end else if (clear_err) begin
      sel_error <= 1'b0;
    end
  end

`ifdef MUX_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count <= 8'd0;
    end else if (clear_err) begin
      err_count <= bad_push ? 8'd1 : 8'd0;
    end else if (bad_push && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
